seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_ctrl_if.sv | 27 ++
 rtl/seg_bcd_dec.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared BCD-to-segment constants and scan FSM state type.
//   SEG_0..SEG_9 : active-low segment patterns, bit order g..a (common anode)
//   SEG_OFF      : all segments dark
//   state_t      : scan FSM states (ST_BLANK, ST_ON)
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display-update handshake bundle.
//   upd_data  : 4*NUM_DIG BCD nibbles, digit 0 in bits [3:0]
//   upd_blank : per-digit blank request, 1 = dark
//   upd_dp    : per-digit decimal point, 1 = lit
//   upd_valid : update offered (master -> slave)
//   upd_ready : pending buffer empty (slave -> master)
interface seg_scan_ctrl_if #(
    parameter int NUM_DIG = 6
);

    logic [4*NUM_DIG-1:0] upd_data;
    logic [NUM_DIG-1:0]   upd_blank;
    logic [NUM_DIG-1:0]   upd_dp;
    logic                 upd_valid;
    logic                 upd_ready;

    modport master (
        output upd_data, upd_blank, upd_dp, upd_valid,
        input  upd_ready
    );

    modport slave (
        input  upd_data, upd_blank, upd_dp, upd_valid,
        output upd_ready
    );

endinterface

// File: rtl/seg_bcd_dec.sv
// seg_bcd_dec: combinational BCD to active-low 7-segment decoder.
//   bcd_i : 4-bit BCD digit; 10..15 decode to all segments dark
//   seg_o : segments g..a, active-low
module seg_bcd_dec
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with frame-synchronous update buffer.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   upd          : update handshake (slave modport)
//   an_o         : digit enables, active-low, at most one low
//   seg_o        : segments g..a, active-low
//   dp_o         : decimal point, active-low
//   frame_tick_o : one-cycle pulse when a full scan frame completes
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIG   = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_ctrl_if.slave     upd,
    output logic [NUM_DIG-1:0] an_o,
    output logic [6:0]         seg_o,
    output logic               dp_o,
    output logic               frame_tick_o
);

    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam int IW   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DIG-1:0]     an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic                   tick_q, tick_d;
    logic [4*NUM_DIG-1:0]   sh_data_q, pend_data_q;
    logic [NUM_DIG-1:0]     sh_blank_q, pend_blank_q;
    logic [NUM_DIG-1:0]     sh_dp_q, pend_dp_q;
    logic                   pend_full_q, pend_full_d;
    logic                   on, last, lit, accept;
    logic [6:0]             dec_seg;

    seg_bcd_dec u_dec (
        .bcd_i (sh_data_q[4*idx_q +: 4]),
        .seg_o (dec_seg)
    );

    // idx only moves on ON->BLANK, so whenever the next state is ON the
    // current idx_q already names the digit about to be (or being) lit.
    // Shadow only changes on that same transition, so the decode is stable
    // for the whole ON window.
    always_comb begin
        on          = (state_q == ST_ON);
        last        = on ? (cnt_q == SCAN_LAST) : (cnt_q == BLANK_LAST);
        state_d     = last ? (on ? ST_BLANK : ST_ON) : state_q;
        cnt_d       = last ? '0 : cnt_q + 1'b1;
        idx_d       = (last && on) ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
        tick_d      = last && on && (idx_q == IDX_LAST);
        lit         = (state_d == ST_ON) && !sh_blank_q[idx_q];
        an_d        = (state_d == ST_ON) ? ~(NUM_DIG'(1) << idx_d) : '1;
        seg_d       = lit ? dec_seg : SEG_OFF;
        dp_d        = lit ? ~sh_dp_q[idx_q] : 1'b1;
        accept      = upd.upd_valid && !pend_full_q;
        // accept and a copy can never coincide: accept needs pend empty,
        // a copy only happens with pend full
        pend_full_d = accept || (pend_full_q && !tick_d);
    end

    assign upd.upd_ready = ~pend_full_q;
    assign an_o          = an_q;
    assign seg_o         = seg_q;
    assign dp_o          = dp_q;
    assign frame_tick_o  = tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            tick_q       <= 1'b0;
            sh_data_q    <= '0;
            sh_blank_q   <= '1;
            sh_dp_q      <= '0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_dp_q    <= '0;
            pend_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            tick_q       <= tick_d;
            pend_full_q  <= pend_full_d;
            if (accept) begin
                pend_data_q  <= upd.upd_data;
                pend_blank_q <= upd.upd_blank;
                pend_dp_q    <= upd.upd_dp;
            end
            // shadow swaps only at frame end so a frame never shows mixed data
            if (tick_d && pend_full_q) begin
                sh_data_q  <= pend_data_q;
                sh_blank_q <= pend_blank_q;
                sh_dp_q    <= pend_dp_q;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scoreboard bench for seg_scan_ctrl (NUM_DIG=6, SCAN_DIV=4, BLANK_CYC=2).
module tb_seg_scan_ctrl;

    localparam int ND = 6;
    localparam int SD = 4;
    localparam int BC = 2;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [7:0] gap;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] an;
    logic [6:0] seg;
    logic dp, ft;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIG(ND)) upd ();

    seg_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk          (clk),
        .rst          (rst),
        .upd          (upd),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp),
        .frame_tick_o (ft)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    disp_t exp_q[$];
    obs_t  obs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    len_bad = 0;
    int    onehot_bad = 0;
    time   t_last = 0;
    time   t_prev = 0;

    // Monitor: records every digit start with the dark gap that preceded it,
    // and tallies ON-window length and one-hot violations.
    logic [5:0] prev_an = 6'h3F;
    int run = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_an = 6'h3F;
            run = 0;
        end else begin
            if ($countones(~an) > 1) onehot_bad++;
            if (an != prev_an) begin
                if (prev_an == 6'h3F) obs_q.push_back('{an, seg, dp, 8'(run)});
                else if (an == 6'h3F) begin
                    if (run != SD) len_bad++;
                end else len_bad++;
                run = 1;
            end else run++;
            prev_an = an;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [23:0] d, input logic [5:0] b, input logic [5:0] p);
        for (int i = 0; i < ND; i++) begin
            disp_t e;
            e.an  = ~(6'd1 << i);
            e.seg = b[i] ? 7'h7F : seg_tab[d[4*i +: 4]];
            e.dp  = b[i] ? 1'b1 : ~p[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_digits(input int k);
        int n = 0;
        while (obs_q.size() < k && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("digits_seen", 32'(obs_q.size() >= k), 1);
        for (int i = 0; i < k && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            obs_t  o;
            disp_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk($sformatf("digit%0d", i), {o.an, o.seg, o.dp}, {e.an, e.seg, e.dp});
            chk($sformatf("gap%0d", i), 32'(o.gap), BC);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ft && n < 200);
        chk("tick_seen", 32'(ft), 1);
        t_prev = t_last;
        t_last = $time;
    endtask

    task automatic offer(input logic [23:0] d, input logic [5:0] b, input logic [5:0] p);
        upd.upd_data  = d;
        upd.upd_blank = b;
        upd.upd_dp    = p;
        upd.upd_valid = 1'b1;
    endtask

    task automatic first_on_latency();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (an == 6'h3F && n < 20);
        chk("first_on_latency", n, 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        upd.upd_data  = '0;
        upd.upd_blank = '0;
        upd.upd_dp    = '0;
        upd.upd_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an, 6'h3F);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_tick", ft, 0);
        chk("rst_ready", upd.upd_ready, 1);

        // idle after reset: two dark cycles then every digit lit but blanked
        @(posedge clk);
        #1 rst = 1'b0;
        obs_q.delete();
        first_on_latency();
        push_frame(24'h0, 6'h3F, 6'h0);
        wait_digits(6);
        wait_tick();

        // first update accepted mid-frame, second offer ignored while full
        repeat (3) @(posedge clk);
        #1 offer(24'h123456, 6'h00, 6'h00);
        @(posedge clk);
        #1 upd.upd_valid = 1'b0;
        chk("ready_after_accept", upd.upd_ready, 0);
        offer(24'hFFFFFF, 6'h3F, 6'h3F);
        repeat (3) @(posedge clk);
        #1 upd.upd_valid = 1'b0;
        chk("ready_while_full", upd.upd_ready, 0);

        // copy at frame end; offer on the tick cycle lands in pending only
        wait_tick();
        chk("frame_period_1", 32'((t_last - t_prev) / 10), 36);
        chk("ready_on_tick", upd.upd_ready, 1);
        obs_q.delete();
        push_frame(24'h123456, 6'h00, 6'h00);
        offer(24'h7A9085, 6'b001000, 6'b001100);
        @(posedge clk);
        #1 upd.upd_valid = 1'b0;
        chk("ready_after_tick_accept", upd.upd_ready, 0);
        chk("tick_one_cycle", ft, 0);
        wait_digits(6);

        wait_tick();
        chk("frame_period_2", 32'((t_last - t_prev) / 10), 36);
        chk("ready_after_copy", upd.upd_ready, 1);
        obs_q.delete();
        push_frame(24'h7A9085, 6'b001000, 6'b001100);
        wait_digits(6);

        // reset during digit 3 with a pending update that must be lost
        wait_tick();
        obs_q.delete();
        offer(24'h000000, 6'h00, 6'h00);
        @(posedge clk);
        #1 upd.upd_valid = 1'b0;
        chk("ready_before_rst", upd.upd_ready, 0);
        begin
            int n = 0;
            while (obs_q.size() < 4 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("on_digit3", an, 6'b110111);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_an", an, 6'h3F);
        chk("async_seg", seg, 7'h7F);
        chk("async_dp", dp, 1);
        chk("async_ready", upd.upd_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        obs_q.delete();
        first_on_latency();
        push_frame(24'h0, 6'h3F, 6'h0);
        wait_digits(6);
        wait_tick();
        obs_q.delete();
        push_frame(24'h0, 6'h3F, 6'h0);
        wait_digits(6);

        chk("on_len_violations", len_bad, 0);
        chk("onehot_violations", onehot_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
